dawson_accum_seq: RTL and testbench

//  Upstream sequencer for a dawson64_if-wrapped double_adder. Buffers a stream of IEEE-754

---
 rtl/dawson_accum_seq.sv | 182 ++++++++++++++++++
 tb/tb_dawson_accum_seq.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dawson_accum_seq.sv
// rtl/dawson_accum_seq.sv - FIFO-buffered sequencer folding double vectors through an external FP adder
// Optional WAIT watchdog with sticky err and vector flush: define DAWSON_ACC_TIMEOUT_EN.
module dawson_accum_seq #(
  parameter int DEPTH   = 4,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [63:0]      in_data,
  input  logic             in_last,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [63:0]      a,
  output logic [63:0]      b,
  output logic             ready_in,
  input  logic [63:0]      out,
  input  logic             ready_out,
  output logic [63:0]      sum,
  output logic             sum_valid,
  output logic [CNT_W-1:0] elem_cnt,
  output logic             busy,
  output logic             err
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [2:0] {
    S_RESET,
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t        state;
  logic [64:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic [64:0]   head;
  logic [63:0]   acc;
  logic          last_q;
  logic          flush_pop;
  logic          drop_active;
  logic          timeout_hit;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign in_ready = !full && (state != S_RESET);
  assign push     = in_valid && in_ready;
  assign head     = mem[rd_ptr];
  assign pop      = (state == S_ISSUE) || flush_pop;
  assign busy     = (state != S_IDLE);

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= {in_last, in_data};
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef DAWSON_ACC_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);

  logic [TO_W-1:0] wait_cnt;
  logic            err_q;
  logic            drop_q;

  assign timeout_hit = (state == S_WAIT) && !ready_out && (wait_cnt == TO_W'(TIMEOUT - 1));
  // Leftover elements of an aborted vector are discarded from IDLE, one per cycle.
  assign flush_pop   = (state == S_IDLE) && drop_q && !empty;
  assign drop_active = drop_q;
  assign err         = err_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt <= '0;
      err_q    <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      if ((state == S_WAIT) && !ready_out) wait_cnt <= wait_cnt + 1'b1;
      else                                 wait_cnt <= '0;
      if (timeout_hit) begin
        err_q  <= 1'b1;
        drop_q <= !last_q;
      end else if (flush_pop && head[64]) begin
        drop_q <= 1'b0;
      end
    end
  end
`else
  logic unused_cfg;

  assign unused_cfg  = ^TIMEOUT;
  assign timeout_hit = 1'b0;
  assign flush_pop   = 1'b0;
  assign drop_active = 1'b0;
  assign err         = 1'b0;
`endif

  // Adder strobes are set on the edge entering ISSUE so they are valid for exactly that cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_RESET;
      acc       <= 64'h0;
      sum       <= 64'h0;
      a         <= 64'h0;
      b         <= 64'h0;
      ready_in  <= 1'b0;
      sum_valid <= 1'b0;
      elem_cnt  <= '0;
      last_q    <= 1'b0;
    end else begin
      ready_in  <= 1'b0;
      sum_valid <= 1'b0;
      a         <= 64'h0;
      b         <= 64'h0;
      case (state)
        S_RESET: state <= S_IDLE;
        S_IDLE: begin
          if (!empty && !drop_active) begin
            state    <= S_ISSUE;
            ready_in <= 1'b1;
            a        <= acc;
            b        <= head[63:0];
          end
        end
        S_ISSUE: begin
          last_q <= head[64];
          if (elem_cnt != '1) elem_cnt <= elem_cnt + 1'b1;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (ready_out) begin
            acc <= out;
            if (last_q) begin
              state     <= S_DONE;
              sum       <= out;
              sum_valid <= 1'b1;
            end else if (!empty) begin
              state    <= S_ISSUE;
              ready_in <= 1'b1;
              a        <= out;
              b        <= head[63:0];
            end else begin
              state <= S_IDLE;
            end
          end else if (timeout_hit) begin
            state    <= S_IDLE;
            acc      <= 64'h0;
            elem_cnt <= '0;
          end
        end
        S_DONE: begin
          acc      <= 64'h0;
          elem_cnt <= '0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dawson_accum_seq.sv
// tb/tb_dawson_accum_seq.sv - directed bench for dawson_accum_seq with a behavioural double adder
module tb_dawson_accum_seq;

  localparam int DEPTH   = 4;
  localparam int CNT_W   = 16;
  localparam int TIMEOUT = 16;

  localparam logic [63:0] D1   = 64'h3FF0000000000000;
  localparam logic [63:0] D2   = 64'h4000000000000000;
  localparam logic [63:0] D3   = 64'h4008000000000000;
  localparam logic [63:0] D5   = 64'h4014000000000000;
  localparam logic [63:0] D6   = 64'h4018000000000000;
  localparam logic [63:0] D21  = 64'h4035000000000000;
  localparam logic [63:0] D123 = 64'h3FF3AE147AE147AE;
  localparam logic [63:0] D456 = 64'h40123D70A3D70A3D;

  logic             clock = 1'b0;
  logic             reset_n = 1'b1;
  logic [63:0]      in_data = '0;
  logic             in_last = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [63:0]      a;
  logic [63:0]      b;
  logic             ready_in;
  logic [63:0]      out = '0;
  logic             ready_out = 1'b0;
  logic [63:0]      sum;
  logic             sum_valid;
  logic [CNT_W-1:0] elem_cnt;
  logic             busy;
  logic             err;

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  logic        stall = 1'b0;
  logic        dead = 1'b0;
  logic        spur = 1'b0;
  logic [63:0] spur_val = '0;
  int          pend = 0;
  logic [63:0] res = '0;
  int          issue_cnt = 0;
  int          sv_cnt = 0;

  always #5 clock = ~clock;

  dawson_accum_seq #(.DEPTH(DEPTH), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset_n(reset_n), .in_data(in_data), .in_last(in_last),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .ready_in(ready_in),
    .out(out), .ready_out(ready_out), .sum(sum), .sum_valid(sum_valid),
    .elem_cnt(elem_cnt), .busy(busy), .err(err)
  );

  // Two-cycle adder: captures on ready_in, answers with a one-cycle ready_out.
  always @(negedge clock) begin
    ready_out = 1'b0;
    out = 64'h0;
    if (!reset_n) begin
      pend = 0;
    end else begin
      if (ready_in) issue_cnt++;
      if (sum_valid) sv_cnt++;
      if (spur) begin
        ready_out = 1'b1;
        out = spur_val;
      end else if (pend > 1) begin
        pend--;
      end else if (pend == 1 && !stall) begin
        ready_out = 1'b1;
        out = res;
        pend = 0;
      end
      if (ready_in && !dead) begin
        res = $realtobits($bitstoreal(a) + $bitstoreal(b));
        pend = 2;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [63:0] d, input logic l);
    int t = 0;
    in_valid = 1'b1;
    in_data = d;
    in_last = l;
    while (!in_ready && t < 200) begin
      tick();
      t++;
    end
    if (t >= 200) chk("push_stuck", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_sv(input string tag);
    int t = 0;
    while (!sum_valid && t < 300) begin
      tick();
      t++;
    end
    chk({tag, "_sum_valid"}, 64'(sum_valid), 64'd1);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    tick();
  endtask

  initial begin
    int i0, s0, acc_n, t;

    #1 reset_n = 1'b0;
    tick();
    tick();
    chk("rst_busy", 64'(busy), 64'd1);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_sum", sum, 64'h0);
    chk("rst_elem_cnt", 64'(elem_cnt), 64'd0);
    chk("rst_ready_in", 64'(ready_in), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    reset_n = 1'b1;
    tick();
    chk("post_rst_idle", 64'(busy), 64'd0);

    // 1.0 + 2.0 + 3.0
    i0 = issue_cnt;
    s0 = sv_cnt;
    push(D1, 1'b0);
    push(D2, 1'b0);
    push(D3, 1'b1);
    wait_sv("v123");
    chk("v123_sum", sum, D6);
    chk("v123_elem_cnt", 64'(elem_cnt), 64'd3);
    tick();
    chk("v123_sv_pulse", 64'(sum_valid), 64'd0);
    chk("v123_elem_clr", 64'(elem_cnt), 64'd0);
    tick();
    chk("v123_issues", 64'(issue_cnt - i0), 64'd3);
    chk("v123_sv_count", 64'(sv_cnt - s0), 64'd1);

    // Single-element vectors, acc cleared between them
    push(D123, 1'b1);
    wait_sv("v123a");
    chk("v1_23_sum", sum, D123);
    push(D456, 1'b1);
    wait_sv("v456");
    chk("v4_56_sum", sum, D456);
    tick();

    // Spurious ready_out in IDLE
    tick();
    s0 = sv_cnt;
    spur_val = 64'hDEAD;
    spur = 1'b1;
    tick();
    spur = 1'b0;
    tick();
    tick();
    chk("spur_sum", sum, D456);
    chk("spur_no_sv", 64'(sv_cnt - s0), 64'd0);
    chk("spur_idle", 64'(busy), 64'd0);
    push(D1, 1'b1);
    wait_sv("spur_next");
    chk("spur_acc_clean", sum, D1);
    tick();

    // Back-pressure: 6 elements with a stalled adder (one in flight plus DEPTH buffered)
    stall = 1'b1;
    acc_n = 0;
    in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_data = $realtobits(real'(i + 1));
      in_last = (i == 5);
      t = 0;
      while (!in_ready && t < 10) begin
        tick();
        t++;
      end
      if (!in_ready) break;
      tick();
      acc_n++;
    end
    chk("bp_in_ready_low", 64'(in_ready), 64'd0);
    chk("bp_accepted", 64'(acc_n), 64'd5);
    stall = 1'b0;
    t = 0;
    while (!in_ready && t < 200) begin
      tick();
      t++;
    end
    tick();
    in_valid = 1'b0;
    wait_sv("bp");
    chk("bp_sum", sum, D21);
    chk("bp_elem_cnt", 64'(elem_cnt), 64'd6);
    tick();

    // Async reset during WAIT
    stall = 1'b1;
    push(D1, 1'b0);
    push(D2, 1'b0);
    tick();
    tick();
    chk("mid_busy", 64'(busy), 64'd1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_sum", sum, 64'h0);
    chk("mid_rst_busy", 64'(busy), 64'd1);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd0);
    chk("mid_rst_elem_cnt", 64'(elem_cnt), 64'd0);
    chk("mid_rst_a", a, 64'h0);
    stall = 1'b0;
    tick();
    reset_n = 1'b1;
    chk("rel_still_reset", 64'(busy), 64'd1);
    tick();
    chk("rel_idle", 64'(busy), 64'd0);
    push(D5, 1'b1);
    wait_sv("after_rst");
    chk("after_rst_sum", sum, D5);
    tick();

    // Adder that never answers
    s0 = sv_cnt;
    i0 = issue_cnt;
    dead = 1'b1;
`ifdef DAWSON_ACC_TIMEOUT_EN
    push(D1, 1'b0);
    push(D2, 1'b0);
    push(D3, 1'b1);
    t = 0;
    while (!err && t < 60) begin
      tick();
      t++;
    end
    chk("to_err_set", 64'(err), 64'd1);
    for (int k = 0; k < 8; k++) tick();
    chk("to_no_sv", 64'(sv_cnt - s0), 64'd0);
    chk("to_idle", 64'(busy), 64'd0);
    chk("to_elem_clr", 64'(elem_cnt), 64'd0);
    dead = 1'b0;
    push(D5, 1'b1);
    wait_sv("to_next");
    chk("to_next_sum", sum, D5);
    chk("to_flushed", 64'(issue_cnt - i0), 64'd2);
    chk("to_err_sticky", 64'(err), 64'd1);
`else
    push(D1, 1'b1);
    for (int k = 0; k < 40; k++) tick();
    chk("nt_err_zero", 64'(err), 64'd0);
    chk("nt_busy_wait", 64'(busy), 64'd1);
    chk("nt_no_sv", 64'(sv_cnt - s0), 64'd0);
    dead = 1'b0;
    do_reset();
    push(D5, 1'b1);
    wait_sv("nt_next");
    chk("nt_next_sum", sum, D5);
`endif
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
